// File: rtl/sram_arbiter.sv
// Round-robin arbiter multiplexing two req/ack clients onto the single-port
// SRAM wrapper interface, holding each access stable for LAT cycles.
module sram_arbiter #(
  parameter int AW  = 18,
  parameter int LAT = 2
) (
  input  logic          clka,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_din,
  output logic          a_ack,
  output logic [7:0]    a_dout,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_din,
  output logic          b_ack,
  output logic [7:0]    b_dout,
  output logic          mem_ena,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q;
  logic          last_b_q;
  logic [CW-1:0] cnt_q;
  logic          a_ack_q, b_ack_q;
  logic          ena_q, wea_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    din_q;
  logic [7:0]    a_dout_q, b_dout_q;
  logic          grant_b_d;

  // last_b_q doubles as the grantee identity for the whole access
  always_comb grant_b_d = b_req && (!a_req || !last_b_q);

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            ena_q    <= 1'b1;
            wea_q    <= grant_b_d ? b_we   : a_we;
            addr_q   <= grant_b_d ? b_addr : a_addr;
            din_q    <= grant_b_d ? b_din  : a_din;
            cnt_q    <= CW'(LAT - 1);
            last_b_q <= grant_b_d;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            ena_q <= 1'b0;
            wea_q <= 1'b0;
            if (!wea_q) begin
              if (last_b_q) b_dout_q <= mem_dout;
              else          a_dout_q <= mem_dout;
            end
            if (last_b_q) b_ack_q <= 1'b1;
            else          a_ack_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_dout   = a_dout_q;
  assign b_dout   = b_dout_q;
  assign mem_ena  = ena_q;
  assign mem_wea  = wea_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-client arbiter that sits directly upstream of the single-port external-SRAM RAM wrapper (spram_sram).
- It time-multiplexes a CPU port (A, read/write) and a video/DMA port (B, read/write) onto the wrapper's ena/wea/addra/dina/douta interface.
- Each client gets a req/ack handshake with registered read data.
- Arbitration is round-robin, so neither client starves.

Parameters:
AW, 18, address width of both client ports and the memory port
LAT, 2, number of cycles mem_ena is held per access (min 1); covers the wrapper's negedge address/data capture

Ports:
clka  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
a_req  in  1  client A request, level, held until a_ack
a_we  in  1  client A write (1) / read (0), valid with a_req
a_addr  in  AW  client A address
a_din  in  8  client A write data
a_ack  out  1  client A completion, one-cycle pulse
a_dout  out  8  client A read data, valid from a_ack onward
b_req  in  1  client B request, level, held until b_ack
b_we  in  1  client B write / read
b_addr  in  AW  client B address
b_din  in  8  client B write data
b_ack  out  1  client B completion, one-cycle pulse
b_dout  out  8  client B read data, valid from b_ack onward
mem_ena  out  1  to wrapper ena
mem_wea  out  1  to wrapper wea
mem_addr  out  AW  to wrapper addra
mem_din  out  8  to wrapper dina
mem_dout  in  8  from wrapper douta

Behaviour:
- Interface: one clock (clka); reset is asynchronous, active-low (reset_n).
- Reset (reset_n low, asynchronous):
  - all outputs 0 (acks, mem_ena, mem_wea, mem_addr, mem_din, a_dout, b_dout);
  - state=IDLE; last_grant=B, so A wins the first tie.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE; mem_ena=0.
  - One request: grant that client.
  - Both requesting: grant the client that is not last_grant.
  - On grant, at the same edge: register the client's we/addr/din into mem_wea/mem_addr/mem_din; mem_ena<=1; cnt<=LAT-1; last_grant<=grantee; go to ACCESS.
- ACCESS:
  - mem_ena, mem_wea, mem_addr and mem_din are held stable for exactly LAT cycles.
  - cnt decrements each cycle.
  - At the edge where cnt==0:
    - mem_ena<=0 and mem_wea<=0;
    - on a read, copy mem_dout into the grantee's dout register;
    - grantee's ack<=1;
    - go to DONE.
- DONE (one cycle):
  - ack high for this cycle only; ack<=0 at the next edge; go to IDLE.
  - The client drops req at the edge where it samples ack.
  - The next grant is therefore decided in IDLE, one cycle later.
- Latency: req sampled at edge 0 → mem_ena high during cycles 1..LAT → ack high in cycle LAT+1. Back-to-back throughput is LAT+2 cycles per access.
- Registers outside the active access:
  - mem_addr and mem_din keep their last value after an access; only mem_ena gates the wrapper.
  - dout of the non-granted client never changes.
  - Write accesses leave the grantee's dout unchanged.
- Request changes during an access: a new req from the other client is ignored until IDLE. A change in the grantee's we/addr/din mid-access is ignored, because the values were captured at grant.
- A req deasserted before ack is a protocol violation. The access still completes and the ack is still pulsed.
- Reset asserted mid-ACCESS: mem_ena and mem_wea drop immediately (asynchronous); no ack is issued. After reset release, the block restarts from IDLE.

Test Plan:
- Read from A (LAT=2, mem_dout model returns 8'h5A for addr 18'h00100): a_req=1 we=0 at edge 0 → mem_ena=1 in cycles 1–2 with mem_addr=18'h00100, a_ack pulse in cycle 3, a_dout=8'h5A; b_ack stays 0.
- Write from B: b_we=1, b_addr=18'h3FFFF, b_din=8'hC3 → mem_wea=1 and mem_din=8'hC3 for exactly 2 cycles, then b_ack pulse; b_dout unchanged.
- Both request out of reset, each holding req and re-requesting after ack → grant order A,B,A,B; four acks in 16 cycles.
- A requests continuously, B raised while A is in ACCESS → B is granted on the next IDLE; A does not win twice in a row.
- LAT=1 build → mem_ena high for 1 cycle; ack in cycle 2; throughput of 3 cycles per access.
- reset_n pulsed low in the second ACCESS cycle → mem_ena=0 asynchronously; no ack; a fresh a_req after release completes normally with the correct data.
